div_share_ctrl: RTL

Shares one external `div32`-class divider core among N requesters. Each requester uses a valid/ready request and response handshake. The block arbitrates requests round-robin and screens out divide-by-zero and quotient overflow without using the core. It then drives the core's operands, waits out the core's fixed latency, and returns the quotient and remainder to the granted requester with its id. One operation is in flight at a time.

---
 rtl/div_share_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/div_share_ctrl.sv
// Round-robin front end that shares one fixed-latency divider core among N requesters.
// Divide-by-zero and quotient overflow are answered directly without occupying the core.
module div_share_ctrl #(
    parameter int K   = 32,
    parameter int N   = 4,
    parameter int LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            req_valid,
    output logic [N-1:0]            req_ready,
    input  logic [N*(K+32)-1:0]     req_x,
    input  logic [N*K-1:0]          req_d,
    output logic [N-1:0]            rsp_valid,
    input  logic [N-1:0]            rsp_ready,
    output logic [$clog2(N)-1:0]    rsp_id,
    output logic [K-1:0]            rsp_q,
    output logic [K-1:0]            rsp_r,
    output logic                    rsp_dz,
    output logic                    rsp_ovf,
    output logic [K+31:0]           core_x,
    output logic [K-1:0]            core_d,
    input  logic [K-1:0]            core_q,
    input  logic [K-1:0]            core_r,
    output logic                    busy
);
    localparam int XW = K + 32;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(LAT + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] id_q, id_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [XW-1:0] core_x_q, core_x_d;
    logic [K-1:0]  core_d_q, core_d_d;
    logic [K-1:0]  rsp_q_q, rsp_q_d;
    logic [K-1:0]  rsp_r_q, rsp_r_d;
    logic          rsp_dz_q, rsp_dz_d;
    logic          rsp_ovf_q, rsp_ovf_d;
    logic [N-1:0]  rsp_valid_q, rsp_valid_d;
    logic          busy_q, busy_d;

    logic          grant_found_s;
    logic [IW-1:0] grant_idx_s;
    logic [XW-1:0] sel_x_s;
    logic [K-1:0]  sel_d_s;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int cand;
        cand          = 0;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int off = 1; off <= N; off++) begin
            cand = (int'(ptr_q) + off) % N;
            if (!grant_found_s && req_valid[cand]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = IW'(cand);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    assign sel_x_s = req_x[int'(grant_idx_s)*XW +: XW];
    assign sel_d_s = req_d[int'(grant_idx_s)*K +: K];

    // Accept strobe: combinational, only in IDLE and never during reset.
    always_comb begin
        req_ready = '0;
        if ((state_q == IDLE) && grant_found_s && !rst) begin
            req_ready[grant_idx_s] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Next-state and datapath update for the single in-flight operation.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        cnt_d     = cnt_q;
        core_x_d  = core_x_q;
        core_d_d  = core_d_q;
        rsp_q_d   = rsp_q_q;
        rsp_r_d   = rsp_r_q;
        rsp_dz_d  = rsp_dz_q;
        rsp_ovf_d = rsp_ovf_q;
        case (state_q)
            IDLE: begin
                if (grant_found_s) begin
                    id_d  = grant_idx_s;
                    ptr_d = grant_idx_s;
                    if (sel_d_s == {K{1'b0}}) begin
                        rsp_dz_d  = 1'b1;
                        rsp_ovf_d = 1'b0;
                        rsp_q_d   = {K{1'b1}};
                        rsp_r_d   = sel_x_s[K-1:0];
                        state_d   = RESP;
                    end else if (sel_x_s[XW-1:K] >= sel_d_s) begin
                        // quotient would not fit in K bits
                        rsp_dz_d  = 1'b0;
                        rsp_ovf_d = 1'b1;
                        rsp_q_d   = {K{1'b1}};
                        rsp_r_d   = {K{1'b0}};
                        state_d   = RESP;
                    end else begin
                        core_x_d = sel_x_s;
                        core_d_d = sel_d_s;
                        cnt_d    = CW'(LAT);
                        state_d  = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == {CW{1'b0}}) begin
                    rsp_q_d   = core_q;
                    rsp_r_d   = core_r;
                    rsp_dz_d  = 1'b0;
                    rsp_ovf_d = 1'b0;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            RESP: begin
                if (rsp_ready[id_q]) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        rsp_valid_d = '0;
        if (state_d == RESP) begin
            rsp_valid_d[id_d] = 1'b1;
        end else begin
            rsp_valid_d = '0;
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= IW'(N - 1);
            id_q        <= '0;
            cnt_q       <= '0;
            core_x_q    <= '0;
            core_d_q    <= '0;
            rsp_q_q     <= '0;
            rsp_r_q     <= '0;
            rsp_dz_q    <= 1'b0;
            rsp_ovf_q   <= 1'b0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            core_x_q    <= core_x_d;
            core_d_q    <= core_d_d;
            rsp_q_q     <= rsp_q_d;
            rsp_r_q     <= rsp_r_d;
            rsp_dz_q    <= rsp_dz_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_q     = rsp_q_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_dz    = rsp_dz_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign core_x    = core_x_q;
    assign core_d    = core_d_q;
    assign busy      = busy_q;

endmodule
